// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and blink-mask field positions for the time-set controller
package timer_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = 2;
    localparam int HOUR_LSB = 4;

    function automatic state_t next_mode(input state_t s);
        case (s)
            RUN:      return SET_HOUR;
            SET_HOUR: return SET_MIN;
            SET_MIN:  return SET_SEC;
            default:  return RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, stability counter and rising-edge press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          armed;
    logic [CW-1:0] cnt;

    // Synchronizer resets to 1 so a button held through reset is never taken as
    // a press; the debouncer only arms once it has seen the button released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            armed   <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            press   <= 1'b0;
            if (!sync_q2)
                armed <= 1'b1;
            if (!armed || (sync_q2 == level)) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_q2;
                press <= sync_q2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - set-mode FSM with auto-repeat, inactivity timeout and digit blink for the HH:MM:SS timer
module time_set_ctrl
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 4,
    parameter int TIMEOUT_S       = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_4hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       run_en,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       inc_hour,
    output logic       clr_sec,
    output logic [5:0] blink_mask,
    output logic [1:0] mode
);

    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam logic [RW-1:0] REP_FULL = RW'(REPEAT_DELAY);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_S - 1);

    logic mode_level, mode_press;
    logic inc_level, inc_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .rst_n(rst_n), .btn(btn_mode), .level(mode_level), .press(mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .rst_n(rst_n), .btn(btn_inc), .level(inc_level), .press(inc_press)
    );

    state_t        state;
    state_t        state_n;
    logic [RW-1:0] rep_cnt;
    logic          rep_arm;
    logic [TW-1:0] tmo_cnt;
    logic          blink_phase;
    logic          phase_n;
    logic          timeout_hit;
    logic          inc_ok;
    logic          rep_fire;
    logic [5:0]    mask_n;

    always_comb begin
        timeout_hit = (state != RUN) && tick_1hz && (tmo_cnt == TMO_LAST);
        state_n     = state;
        if (mode_press)
            state_n = next_mode(state);
        else if (timeout_hit)
            state_n = RUN;
        inc_ok   = inc_press && !mode_press;
        rep_fire = rep_arm && inc_level && tick_4hz && (rep_cnt == REP_FULL) && !mode_press;
        phase_n  = blink_phase ^ tick_4hz;
        // The field being edited stays lit while the increment button is held.
        mask_n = '0;
        if (!inc_level) begin
            case (state_n)
                SET_HOUR: mask_n[HOUR_LSB +: 2] = {2{phase_n}};
                SET_MIN:  mask_n[MIN_LSB +: 2]  = {2{phase_n}};
                SET_SEC:  mask_n[SEC_LSB +: 2]  = {2{phase_n}};
                default:  mask_n = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            mode        <= 2'd0;
            run_en      <= 1'b1;
            inc_sec     <= 1'b0;
            inc_min     <= 1'b0;
            inc_hour    <= 1'b0;
            clr_sec     <= 1'b0;
            blink_mask  <= '0;
            blink_phase <= 1'b0;
            rep_cnt     <= '0;
            rep_arm     <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            state       <= state_n;
            mode        <= state_n;
            run_en      <= (state_n == RUN);
            blink_phase <= phase_n;
            blink_mask  <= mask_n;
            inc_hour    <= (state == SET_HOUR) && (inc_ok || rep_fire);
            inc_min     <= (state == SET_MIN) && (inc_ok || rep_fire);
            inc_sec     <= 1'b0;
            clr_sec     <= (state == SET_SEC) && inc_ok;

            // Repeat only follows a press made in the current state.
            if (!inc_level || (state_n != state)) begin
                rep_cnt <= '0;
                rep_arm <= 1'b0;
            end else if (inc_ok && ((state == SET_HOUR) || (state == SET_MIN))) begin
                rep_cnt <= '0;
                rep_arm <= 1'b1;
            end else if (rep_arm && tick_4hz && (rep_cnt != REP_FULL)) begin
                rep_cnt <= rep_cnt + 1'b1;
            end

            if ((state == RUN) || (state_n != state) || inc_press)
                tmo_cnt <= '0;
            else if (tick_1hz)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - scoreboard bench for time_set_ctrl with directed button and tick vectors
module tb_time_set_ctrl;

    localparam int EV_MODE = 0;
    localparam int EV_HOUR = 1;
    localparam int EV_MIN  = 2;
    localparam int EV_SEC  = 3;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_4hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       run_en;
    logic       inc_sec, inc_min, inc_hour, clr_sec;
    logic [5:0] blink_mask;
    logic [1:0] mode;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   exp_phase = 1'b0;
    logic [1:0] prev_mode = 2'd0;
    ev_t  exp_q[$];

    time_set_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(4), .TIMEOUT_S(3)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_4hz(tick_4hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .run_en(run_en),
        .inc_sec(inc_sec), .inc_min(inc_min), .inc_hour(inc_hour), .clr_sec(clr_sec),
        .blink_mask(blink_mask), .mode(mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d val %0d at cycle %0d, expected none", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_val", val, e.val);
            check("event_cycle", cyc, e.cyc);
            if (kind == EV_MODE)
                check("run_en_on_mode", int'(run_en), int'(val == 0));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mode != prev_mode) observe(EV_MODE, int'(mode));
            if (inc_hour) observe(EV_HOUR, 0);
            if (inc_min)  observe(EV_MIN, 0);
            if (clr_sec)  observe(EV_SEC, 0);
            if (inc_sec)  observe(4, 0);
            prev_mode = mode;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick4();
        tick_4hz = 1'b1;
        step(1);
        tick_4hz = 1'b0;
        exp_phase = ~exp_phase;
        step(3);
    endtask

    task automatic press_mode(input int new_mode);
        push(EV_MODE, new_mode, cyc + 7);
        btn_mode = 1'b1;
        step(10);
        btn_mode = 1'b0;
        step(10);
    endtask

    initial begin
        step(4);
        rst_n = 1'b1;
        step(1);
        check("reset_run_en", int'(run_en), 1);
        check("reset_mode", int'(mode), 0);
        check("reset_blink_mask", int'(blink_mask), 0);
        check("reset_pulses", int'({inc_hour, inc_min, inc_sec, clr_sec}), 0);
        mon_en = 1'b1;
        step(10);

        // two-cycle glitch must be rejected
        btn_mode = 1'b1;
        step(2);
        btn_mode = 1'b0;
        step(12);
        check("glitch_mode", int'(mode), 0);

        press_mode(1);

        // SET_HOUR: one press pulse, then repeats on ticks 5 and 6
        push(EV_HOUR, 0, cyc + 7);
        btn_inc = 1'b1;
        step(8);
        check("held_mask_hour", int'(blink_mask), 0);
        for (int t = 1; t <= 6; t++) begin
            if (t >= 5) push(EV_HOUR, 0, cyc + 1);
            tick4();
        end
        btn_inc = 1'b0;
        step(10);

        press_mode(2);
        press_mode(3);

        // SET_SEC: single clear pulse, no auto-repeat
        push(EV_SEC, 0, cyc + 7);
        btn_inc = 1'b1;
        step(8);
        for (int t = 1; t <= 8; t++) tick4();
        btn_inc = 1'b0;
        step(10);

        press_mode(0);
        check("run_en_in_run", int'(run_en), 1);
        press_mode(1);
        press_mode(2);

        // SET_MIN: blink toggles, then inactivity timeout returns to RUN
        for (int t = 1; t <= 2; t++) begin
            tick4();
            check("blink_min", int'(blink_mask), int'({2'b00, {2{exp_phase}}, 2'b00}));
        end
        for (int t = 1; t <= 3; t++) begin
            if (t == 3) push(EV_MODE, 0, cyc + 1);
            tick_1hz = 1'b1;
            step(1);
            tick_1hz = 1'b0;
            step(3);
        end
        check("timeout_mask", int'(blink_mask), 0);
        check("timeout_run_en", int'(run_en), 1);

        press_mode(1);

        // both buttons rise together: mode wins, increment discarded
        push(EV_MODE, 2, cyc + 7);
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        step(10);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        step(10);

        // fresh press in SET_MIN with auto-repeat
        push(EV_MIN, 0, cyc + 7);
        btn_inc = 1'b1;
        step(8);
        for (int t = 1; t <= 6; t++) begin
            if (t >= 5) push(EV_MIN, 0, cyc + 1);
            tick4();
        end
        btn_inc = 1'b0;
        step(20);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Controller for the time-setting flow of the HH:MM:SS timer. It takes two raw push-buttons (mode, increment) and the 1 Hz / 4 Hz tick pulses, and runs a set-mode state machine. From that it drives the count enable, per-field increment and clear pulses, and a digit blink mask. It sits between the board buttons and the sec/min/hour counter chain and the seven-segment scanner, replacing hard-wired switch muxing of counter clocks with synchronous enables.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable clk cycles required to accept a button level change (10 ms at 100 MHz).
- REPEAT_DELAY, 4: tick_4hz pulses a held increment button must stay down before auto-repeat starts.
- TIMEOUT_S, 30: tick_1hz pulses with no accepted press before a set state returns to RUN.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- tick_1hz  in  1  one-cycle pulse, 1 Hz, synchronous to clk.
- tick_4hz  in  1  one-cycle pulse, 4 Hz, synchronous to clk.
- btn_mode  in  1  raw mode button, asynchronous, active-high.
- btn_inc  in  1  raw increment button, asynchronous, active-high.
- run_en  out  1  seconds counter count enable; 1 only in RUN.
- inc_sec, inc_min, inc_hour  out  1 each  one-cycle increment pulses to the matching counter.
- clr_sec  out  1  one-cycle pulse that zeroes the seconds field.
- blink_mask  out  6  per-digit blank request; [1:0] seconds, [3:2] minutes, [5:4] hours; 1 = blank.
- mode  out  2  current state encoding, for status LEDs.

## Operation
- Each button: 2-flop synchronizer, then debounce counter. The counter clears whenever the synced level equals the accepted level. When it reaches DEBOUNCE_CYCLES-1 with levels still differing, the accepted level flips. A press is a rising edge of the accepted level.
- States (mode encoding): RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.
- A mode press advances RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- RUN: run_en=1. Increment presses are ignored.
- SET_HOUR / SET_MIN: run_en=0.
  - An increment press gives one inc_hour / inc_min pulse.
  - While the button is held, the repeat counter counts tick_4hz pulses. On reaching REPEAT_DELAY, every subsequent tick_4hz gives one further pulse.
  - Release clears the repeat counter.
- SET_SEC: run_en=0. An increment press gives one clr_sec pulse. No auto-repeat.
- Timeout counter:
  - Counts tick_1hz pulses in set states.
  - Clears on any accepted press and on state change.
  - On reaching TIMEOUT_S the state goes to RUN.
- Blink:
  - blink_phase toggles on every tick_4hz (2 Hz blink).
  - In a set state, the selected field's two mask bits equal blink_phase. They are forced 0 while btn_inc is held, so the value stays readable during auto-repeat.
  - All other bits are 0. In RUN, mask = 0.
- Boundary cases:
  - Mode and increment presses in the same cycle: mode wins and the increment is discarded.
  - Mode press while the increment button is held: repeat counter cleared; no pulse in the new state until a fresh press.
  - Press and tick_4hz in the same cycle: exactly one pulse.
  - Timeout and mode press in the same cycle: the press wins (advance), not RUN.
  - Reset mid-hold: the button must be released and pressed again before it is accepted.

## Timing
- All outputs are registered.
- Reset values: state RUN, run_en=1, mode=0, all pulses 0, blink_mask=0, blink_phase=0, all counters 0, accepted button levels 0.
- Press latency: raw edge → accepted edge in 2 + DEBOUNCE_CYCLES cycles. Pulse / state update follows 1 cycle later.
- Auto-repeat pulse: asserted the cycle after the qualifying tick_4hz. Width exactly 1 cycle.
- run_en and mode change in the same cycle as the state register.

## Structure
- timer_pkg holds:
  - state typedef (2-bit enum RUN/SET_HOUR/SET_MIN/SET_SEC);
  - blink_mask field index constants (SEC_LSB=0, MIN_LSB=2, HOUR_LSB=4).
- One sub-module, btn_debounce (sync + debounce + rise pulse, parameter DEBOUNCE_CYCLES), instanced twice.
- FSM, repeat, timeout and blink logic live in time_set_ctrl.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=4, TIMEOUT_S=3.
- Reset then idle → run_en=1, mode=0, blink_mask=0, no pulses.
- btn_mode glitch of 2 cycles → no state change. Held 10 cycles → mode=1 exactly 7 cycles after the rising edge.
- mode=1, btn_inc held across 6 tick_4hz → one press pulse plus 2 repeat pulses on inc_hour (ticks 5, 6); inc_min / inc_sec stay 0.
- mode=3, btn_inc press → one clr_sec pulse; holding across 8 tick_4hz gives no further pulses.
- mode=2, no presses for 3 tick_1hz → mode=0, run_en=1 the cycle after the 3rd tick. Blink bits [3:2] toggle every tick_4hz before the timeout.
- Both buttons rise in the same cycle in mode=1 → mode=2, no inc_hour / inc_min pulse.
